// File: rtl/pheap_req_arb.sv
// pheap_req_arb: request front-end for the pheap priority queue.
// Buffers per-core enqueue requests in small FIFOs, arbitrates them
// round-robin against dispatcher dequeue requests, and drives the heap's
// single enq/deq port at most once per IDLE -> ISSUE -> GAP sequence.
module pheap_req_arb #(
  parameter int NCORES = 4,
  parameter int DWIDTH = 32,
  parameter int FDLOG  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCORES-1:0]        core_enq_valid,
  input  logic [NCORES*DWIDTH-1:0] core_enq_data,
  output logic [NCORES-1:0]        core_enq_ready,
  input  logic                     deq_req,
  output logic                     deq_valid,
  output logic [DWIDTH-1:0]        deq_data,
  output logic                     pq_enq,
  output logic                     pq_deq,
  output logic [DWIDTH-1:0]        pq_inp_data,
  input  logic [DWIDTH-1:0]        pq_out_data,
  input  logic                     pq_full,
  input  logic                     pq_empty,
  input  logic                     pq_ready
);

  localparam int DEPTH = 1 << FDLOG;
  localparam int CW    = FDLOG + 1;
  localparam int RW    = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;
  typedef enum logic       {OP_ENQ, OP_DEQ}         op_e;

  // Control state
  state_e              state_q, state_d;
  op_e                 last_op_q, last_op_d;
  logic [RW-1:0]       rr_q, rr_d;
  logic                pq_enq_q, pq_enq_d;
  logic                pq_deq_q, pq_deq_d;
  logic [DWIDTH-1:0]   pq_inp_data_q, pq_inp_data_d;
  logic                deq_valid_q, deq_valid_d;
  logic [DWIDTH-1:0]   deq_data_q, deq_data_d;

  // Per-core FIFO state
  logic [NCORES-1:0][DEPTH-1:0][DWIDTH-1:0] mem_q;
  logic [NCORES-1:0][FDLOG-1:0]             wr_ptr_q, wr_ptr_d;
  logic [NCORES-1:0][FDLOG-1:0]             rd_ptr_q, rd_ptr_d;
  logic [NCORES-1:0][CW-1:0]                count_q, count_d;
  logic [NCORES-1:0]                        ready_q, ready_d;

  logic [NCORES-1:0] push;
  logic [NCORES-1:0] pop;
  logic [NCORES-1:0] nonempty;
  logic              deq_ok;
  logic              enq_ok;
  logic [RW-1:0]     win_idx;
  logic [DWIDTH-1:0] head_data;
  int                cand;

  // Eligibility of each operation in the IDLE cycle
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      nonempty[i] = (count_q[i] != '0);
    end
    deq_ok = deq_req & ~pq_empty & pq_ready & ~deq_valid_q;
    enq_ok = (|nonempty) & ~pq_full & pq_ready;
  end

  // Round-robin winner: first non-empty FIFO after the last served core
  always_comb begin
    win_idx = '0;
    cand    = 0;
    for (int k = NCORES; k >= 1; k--) begin
      cand = (int'(rr_q) + k) % NCORES;
      if (nonempty[cand]) begin
        win_idx = RW'(cand);
      end
    end
    head_data = mem_q[win_idx][rd_ptr_q[win_idx]];
  end

  // FSM next state, operation select and dequeue capture
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d       = state_q;
    last_op_d     = last_op_q;
    rr_d          = rr_q;
    pq_enq_d      = 1'b0;
    pq_deq_d      = 1'b0;
    pq_inp_data_d = pq_inp_data_q;
    pop           = '0;
    deq_valid_d   = pq_deq_q;
    deq_data_d    = pq_deq_q ? pq_out_data : deq_data_q;
    case (state_q)
      S_IDLE: begin
        if (deq_ok || enq_ok) begin
          state_d = S_ISSUE;
          // With both eligible, serve the opposite of the previous op.
          if (enq_ok && (!deq_ok || last_op_q == OP_DEQ)) begin
            pq_enq_d      = 1'b1;
            pq_inp_data_d = head_data;
            pop[win_idx]  = 1'b1;
            rr_d          = win_idx;
            last_op_d     = OP_ENQ;
          end else begin
            pq_deq_d  = 1'b1;
            last_op_d = OP_DEQ;
          end
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer, occupancy and ready bookkeeping
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      push[i]     = core_enq_valid[i] & ready_q[i];
      wr_ptr_d[i] = wr_ptr_q[i] + FDLOG'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + FDLOG'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      ready_d[i]  = (count_d[i] != CW'(DEPTH));
    end
  end

  // FIFO storage write
  // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= core_enq_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_op_q     <= OP_DEQ;
      rr_q          <= '0;
      pq_enq_q      <= 1'b0;
      pq_deq_q      <= 1'b0;
      pq_inp_data_q <= '0;
      deq_valid_q   <= 1'b0;
      deq_data_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= '1;
    end else begin
      state_q       <= state_d;
      last_op_q     <= last_op_d;
      rr_q          <= rr_d;
      pq_enq_q      <= pq_enq_d;
      pq_deq_q      <= pq_deq_d;
      pq_inp_data_q <= pq_inp_data_d;
      deq_valid_q   <= deq_valid_d;
      deq_data_q    <= deq_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
    end
  end

  assign core_enq_ready = ready_q;
  assign pq_enq         = pq_enq_q;
  assign pq_deq         = pq_deq_q;
  assign pq_inp_data    = pq_inp_data_q;
  assign deq_valid      = deq_valid_q;
  assign deq_data       = deq_data_q;

endmodule
